// File: rtl/regbank_dump_ctrl.sv
// Register-bank port controller: gates writeback writes (HALT latch, r0 protection)
// and streams the whole bank to the debug unit over a valid/ready handshake.
module regbank_dump_ctrl #(
   parameter int DATA_SIZE = 32,
   parameter int REG_SIZE  = 5,
   parameter int NUM_REGS  = 32
) (
   input  logic                 i_clk,
   input  logic                 i_reset_n,
   input  logic                 i_wb_reg_write,
   input  logic [REG_SIZE-1:0]  i_wb_reg,
   input  logic [DATA_SIZE-1:0] i_wb_data,
   input  logic                 i_wb_halt,
   input  logic                 i_dump_req,
   input  logic [DATA_SIZE-1:0] i_rf_rd_data,
   input  logic                 i_tx_ready,
   output logic                 o_rf_wr_en,
   output logic [REG_SIZE-1:0]  o_rf_wr_reg,
   output logic [DATA_SIZE-1:0] o_rf_wr_data,
   output logic [REG_SIZE-1:0]  o_rf_rd_addr,
   output logic [DATA_SIZE-1:0] o_tx_data,
   output logic                 o_tx_valid,
   output logic                 o_pipe_stall,
   output logic                 o_halted,
   output logic                 o_busy,
   output logic                 o_done
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_READ,
      ST_SEND,
      ST_DONE
   } state_t;

   localparam logic [REG_SIZE-1:0] LAST_IDX = REG_SIZE'(NUM_REGS - 1);

   state_t               r_state;
   state_t               w_state_next;
   logic [REG_SIZE-1:0]  r_idx;
   logic [REG_SIZE-1:0]  w_idx_next;
   logic [DATA_SIZE-1:0] r_tx_data;
   logic                 r_halted;
   logic                 w_handshake;
   logic                 w_busy;

   assign w_busy      = (r_state == ST_READ) || (r_state == ST_SEND);
   assign w_handshake = (r_state == ST_SEND) && i_tx_ready;

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state   <= ST_IDLE;
         r_idx     <= '0;
         r_tx_data <= '0;
      end else begin
         r_state <= w_state_next;
         r_idx   <= w_idx_next;
         // Read data is captured on the edge that leaves READ and held through SEND.
         if (r_state == ST_READ) begin
            r_tx_data <= i_rf_rd_data;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_halted <= 1'b0;
      end else if (i_wb_halt) begin
         r_halted <= 1'b1;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_idx_next   = r_idx;
      case (r_state)
         ST_IDLE: begin
            if (i_dump_req) begin
               w_idx_next   = '0;
               w_state_next = ST_READ;
            end
         end
         ST_READ: begin
            w_state_next = ST_SEND;
         end
         ST_SEND: begin
            if (w_handshake) begin
               if (r_idx == LAST_IDX) begin
                  w_state_next = ST_DONE;
               end else begin
                  w_idx_next   = r_idx + 1'b1;
                  w_state_next = ST_READ;
               end
            end
         end
         ST_DONE: begin
            w_state_next = ST_IDLE;
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   // HALT in the current writeback cycle suppresses its own write before the flag registers.
   assign o_rf_wr_en   = i_wb_reg_write && (i_wb_reg != '0) && !i_wb_halt && !r_halted && !w_busy;
   assign o_rf_wr_reg  = i_wb_reg;
   assign o_rf_wr_data = i_wb_data;
   assign o_rf_rd_addr = r_idx;
   assign o_tx_data    = r_tx_data;
   assign o_tx_valid   = (r_state == ST_SEND);
   assign o_pipe_stall = (r_state != ST_IDLE);
   assign o_halted     = r_halted;
   assign o_busy       = w_busy;
   assign o_done       = (r_state == ST_DONE);

endmodule
